// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the car-park barrier gate controller.
package parking_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OPEN = 1'b1
    } gate_state_t;

    localparam logic GATE_DIR_IN  = 1'b0;
    localparam logic GATE_DIR_OUT = 1'b1;

    localparam int unsigned CAR_MIN_DEF   = 2;
    localparam int unsigned CAR_MAX_DEF   = 10;
    localparam int unsigned GATE_HOLD_DEF = 8;

endpackage

// File: rtl/parking_gate_ctrl_classifier.sv
// Per-lane tyre pulse classifier: measures high width of the debounced sensor
// and flags a car event on the falling edge when the width is in the car window.
module tyre_pulse_classifier
    import parking_pkg::*;
#(
    parameter int unsigned PW_W    = 4,
    parameter int unsigned CAR_MIN = CAR_MIN_DEF,
    parameter int unsigned CAR_MAX = CAR_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic db,
    output logic car_evt
);

    logic            db_q;
    logic [PW_W-1:0] width;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            db_q  <= 1'b0;
            width <= '0;
        end else begin
            db_q <= db;
            if (!db)
                width <= '0;
            else if (width != '1)
                width <= width + 1'b1;
        end
    end

    // width already holds the full high count in the cycle the fall is seen
    assign car_evt = db_q && !db
                     && (width >= PW_W'(CAR_MIN))
                     && (width <= PW_W'(CAR_MAX));

endmodule

// File: rtl/parking_gate_ctrl.sv
// Barrier gate sequencer for an entry/exit lane pair: captures car requests,
// arbitrates the shared gate (exit first) and tracks occupancy against capacity.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned CAP       = 16,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned PW_W      = 4,
    parameter int unsigned CAR_MIN   = CAR_MIN_DEF,
    parameter int unsigned CAR_MAX   = CAR_MAX_DEF,
    parameter int unsigned GATE_HOLD = GATE_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_db,
    input  logic             exit_db,
    output logic             gate_open,
    output logic             gate_dir,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             entry_reject,
    output logic             err_underflow
);

    localparam int unsigned HOLD_W = (GATE_HOLD > 2) ? $clog2(GATE_HOLD) : 1;

    gate_state_t       state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              pend_in;
    logic              pend_out;
    logic              entry_evt;
    logic              exit_evt;
    logic              grant_in;
    logic              grant_out;
    logic              exit_underflow;
    logic [CNT_W-1:0]  occ_next;

    tyre_pulse_classifier #(
        .PW_W    (PW_W),
        .CAR_MIN (CAR_MIN),
        .CAR_MAX (CAR_MAX)
    ) u_entry_cls (
        .clk     (clk),
        .rst_n   (rst_n),
        .db      (entry_db),
        .car_evt (entry_evt)
    );

    tyre_pulse_classifier #(
        .PW_W    (PW_W),
        .CAR_MIN (CAR_MIN),
        .CAR_MAX (CAR_MAX)
    ) u_exit_cls (
        .clk     (clk),
        .rst_n   (rst_n),
        .db      (exit_db),
        .car_evt (exit_evt)
    );

    assign exit_underflow = exit_evt && (occupancy == '0) && !pend_out;

    always_comb begin
        grant_in  = 1'b0;
        grant_out = 1'b0;
        if (state == IDLE) begin
            if (pend_out)
                grant_out = 1'b1;
            else if (pend_in && (occupancy < CNT_W'(CAP)))
                grant_in = 1'b1;
        end
        occ_next = occupancy;
        if (grant_out && (occupancy != '0))
            occ_next = occupancy - 1'b1;
        else if (grant_in)
            occ_next = occupancy + 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            pend_in       <= 1'b0;
            pend_out      <= 1'b0;
            gate_dir      <= GATE_DIR_IN;
            occupancy     <= '0;
            full          <= 1'b0;
            entry_reject  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            entry_reject  <= entry_evt && full;
            err_underflow <= exit_underflow;

            // a new event in the grant cycle re-arms the flag rather than being lost
            if (entry_evt && !full)
                pend_in <= 1'b1;
            else if (grant_in)
                pend_in <= 1'b0;

            if (exit_evt && !exit_underflow)
                pend_out <= 1'b1;
            else if (grant_out)
                pend_out <= 1'b0;

            occupancy <= occ_next;
            full      <= (occ_next == CNT_W'(CAP));

            case (state)
                IDLE: begin
                    if (grant_out || grant_in) begin
                        state    <= OPEN;
                        hold_cnt <= HOLD_W'(GATE_HOLD - 1);
                        gate_dir <= grant_out ? GATE_DIR_OUT : GATE_DIR_IN;
                    end
                end
                OPEN: begin
                    if (hold_cnt == '0)
                        state <= IDLE;
                    else
                        hold_cnt <= hold_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gate_open = (state == OPEN);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: directed lane pulses push expected
// gate openings / reject / underflow pulses; a negedge monitor pops and compares.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_db;
    logic       exit_db;
    logic       gate_open;
    logic       gate_dir;
    logic [4:0] occupancy;
    logic       full;
    logic       entry_reject;
    logic       err_underflow;

    typedef struct {
        int start;
        int dir;
        int occ;
        int full;
        int len;
    } exp_t;

    exp_t q_gate[$];
    exp_t q_rej[$];
    exp_t q_unf[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    parking_gate_ctrl #(
        .CAP       (16),
        .CNT_W     (5),
        .PW_W      (4),
        .CAR_MIN   (2),
        .CAR_MAX   (10),
        .GATE_HOLD (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .entry_db      (entry_db),
        .exit_db       (exit_db),
        .gate_open     (gate_open),
        .gate_dir      (gate_dir),
        .occupancy     (occupancy),
        .full          (full),
        .entry_reject  (entry_reject),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic string chname(int ch);
        case (ch)
            0:       return "gate";
            1:       return "reject";
            default: return "underflow";
        endcase
    endfunction

    function automatic bit pop_exp(int ch, output exp_t e);
        bit ok;
        ok = 1'b0;
        e  = '{default: 0};
        case (ch)
            0: if (q_gate.size() > 0) begin e = q_gate.pop_front(); ok = 1'b1; end
            1: if (q_rej.size()  > 0) begin e = q_rej.pop_front();  ok = 1'b1; end
            default: if (q_unf.size() > 0) begin e = q_unf.pop_front(); ok = 1'b1; end
        endcase
        return ok;
    endfunction

    // Monitor: every high run of gate_open / entry_reject / err_underflow
    // must match the next expectation for that channel.
    logic [2:0] prev   = '0;
    logic [2:0] active = '0;
    int         run_len[3];
    exp_t       cur[3];

    always @(negedge clk) begin
        logic [2:0] s;
        s = {err_underflow, entry_reject, gate_open};
        for (int ch = 0; ch < 3; ch++) begin
            if (s[ch] && !prev[ch]) begin
                run_len[ch] = 1;
                if (!pop_exp(ch, cur[ch])) begin
                    check({chname(ch), "_unexpected"}, 1, 0);
                end else begin
                    active[ch] = 1'b1;
                    check({chname(ch), "_start"}, cyc, cur[ch].start);
                    check({chname(ch), "_occ"}, int'(occupancy), cur[ch].occ);
                    check({chname(ch), "_full"}, int'(full), cur[ch].full);
                    if (ch == 0)
                        check("gate_dir", int'(gate_dir), cur[ch].dir);
                end
            end else if (s[ch]) begin
                run_len[ch]++;
            end else if (prev[ch] && active[ch]) begin
                check({chname(ch), "_len"}, run_len[ch], cur[ch].len);
                active[ch] = 1'b0;
            end
        end
        prev = s;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(int n);
        repeat (n) step();
    endtask

    task automatic pulse_entry(int w, output int fall);
        entry_db = 1'b1;
        repeat (w) step();
        entry_db = 1'b0;
        fall = cyc;
    endtask

    task automatic pulse_exit(int w, output int fall);
        exit_db = 1'b1;
        repeat (w) step();
        exit_db = 1'b0;
        fall = cyc;
    endtask

    task automatic push_gate(int start, int dir, int occ, int fl, int len);
        q_gate.push_back('{start: start, dir: dir, occ: occ, full: fl, len: len});
    endtask

    task automatic push_pulse(int ch, int start, int occ, int fl);
        if (ch == 1)
            q_rej.push_back('{start: start, dir: 0, occ: occ, full: fl, len: 1});
        else
            q_unf.push_back('{start: start, dir: 0, occ: occ, full: fl, len: 1});
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int sw_w[5];
        int sw_occ[5];

        rst_n    = 1'b1;
        entry_db = 1'b0;
        exit_db  = 1'b0;
        gap(3);
        check("rst_gate_open", int'(gate_open), 0);
        check("rst_gate_dir", int'(gate_dir), 0);
        check("rst_occupancy", int'(occupancy), 0);
        check("rst_full", int'(full), 0);
        check("rst_entry_reject", int'(entry_reject), 0);
        check("rst_err_underflow", int'(err_underflow), 0);
        rst_n = 1'b0;
        gap(2);

        // entry width 5 at occupancy 0
        pulse_entry(5, f);
        push_gate(f + 2, 0, 1, 0, 8);
        gap(14);

        // width sweep from empty: only 2 and 10 are cars
        do_reset();
        sw_w   = '{1, 2, 10, 11, 20};
        sw_occ = '{0, 1, 2, 0, 0};
        for (int i = 0; i < 5; i++) begin
            pulse_entry(sw_w[i], f);
            if (sw_occ[i] != 0)
                push_gate(f + 2, 0, sw_occ[i], 0, 8);
            gap(14);
        end
        check("sweep_final_occ", int'(occupancy), 2);

        // fill to capacity, then reject, then exit frees a space
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pulse_entry(3, f);
            push_gate(f + 2, 0, i + 1, (i == 15) ? 1 : 0, 8);
            gap(12);
        end
        check("full_after_16", int'(full), 1);
        pulse_entry(4, f);
        push_pulse(1, f + 1, 16, 1);
        gap(12);
        check("occ_after_reject", int'(occupancy), 16);
        pulse_exit(4, f);
        push_gate(f + 2, 1, 15, 0, 8);
        gap(14);
        check("full_after_exit", int'(full), 0);

        // exit at occupancy 0
        do_reset();
        pulse_exit(3, f);
        push_pulse(2, f + 1, 0, 0);
        gap(14);
        check("occ_after_underflow", int'(occupancy), 0);

        // simultaneous entry and exit at occupancy 3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse_entry(3, f);
            push_gate(f + 2, 0, i + 1, 0, 8);
            gap(12);
        end
        entry_db = 1'b1;
        exit_db  = 1'b1;
        gap(4);
        entry_db = 1'b0;
        exit_db  = 1'b0;
        f = cyc;
        push_gate(f + 2, 1, 2, 0, 8);
        push_gate(f + 11, 0, 3, 0, 8);
        gap(24);

        // reset during the 4th open cycle with an exit request pending
        pulse_entry(5, f);
        push_gate(f + 2, 0, 4, 0, 3);
        step();
        exit_db = 1'b1;
        gap(2);
        exit_db = 1'b0;
        gap(2);
        #1;
        rst_n = 1'b1;
        #1;
        check("midreset_gate_open", int'(gate_open), 0);
        check("midreset_occupancy", int'(occupancy), 0);
        check("midreset_full", int'(full), 0);
        step();
        rst_n = 1'b0;
        gap(20);
        check("post_reset_occ", int'(occupancy), 0);

        check("leftover_gate", q_gate.size(), 0);
        check("leftover_reject", q_rej.size(), 0);
        check("leftover_underflow", q_unf.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

- Sequences the single barrier gate of a car-park lane pair.
- Consumes the debounced tyre-sensor levels from the entry and exit lanes and classifies each pulse by width: car-tyre window or rejected cycle/noise.
- Arbitrates the shared gate between entry and exit requests and maintains the occupancy count against capacity.
- Sits directly downstream of the per-lane debouncers and drives the gate actuator and occupancy display.

## Interface

- CAP, 16: parking capacity, in cars.
- CNT_W, 5: occupancy counter width; must satisfy 2^CNT_W > CAP.
- PW_W, 4: pulse-width counter width.
- CAR_MIN, 2: minimum high width, in cycles, accepted as a car tyre.
- CAR_MAX, 10: maximum high width, in cycles, accepted as a car tyre; must satisfy CAR_MAX < 2^PW_W-1.
- GATE_HOLD, 8: number of cycles gate_open stays asserted per served car.

- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous and active-high (asserted when 1).
- entry_db  in  1  debounced entry-lane tyre sensor level.
- exit_db  in  1  debounced exit-lane tyre sensor level.
- gate_open  out  1  gate actuator enable.
- gate_dir  out  1  direction of the current opening: 0 = inbound, 1 = outbound.
- occupancy  out  CNT_W  cars currently parked.
- full  out  1  high when occupancy == CAP.
- entry_reject  out  1  one-cycle pulse: car event at entry dropped because the park was full.
- err_underflow  out  1  one-cycle pulse: exit car event dropped because occupancy was 0.

## Operation

**Reset values:** all outputs 0, state IDLE, pending flags 0, width counters 0.

**Per-lane classifier (entry and exit identical)**
- db_q registers db.
- Width counter:
  - cleared to 0 while db = 0;
  - increments each cycle db = 1, starting at 1 on the first high cycle;
  - saturates at 2^PW_W-1.
- Falling edge (db_q = 1, db = 0): width is the counter value, valid in that cycle.
- car_evt pulses for one cycle when CAR_MIN <= width <= CAR_MAX.
- Any other width is silently discarded, whether shorter (cycle tyre or noise) or longer (saturated or stuck).

**Request capture**
- Entry car_evt with full = 1: pulse entry_reject on the next cycle; no pending flag is set.
- Entry car_evt otherwise: set pend_in.
- Exit car_evt with occupancy = 0 and pend_out = 0: pulse err_underflow; no pending flag is set.
- Exit car_evt otherwise: set pend_out.
- A second event on a lane whose flag is already set merges into that flag. No queueing beyond one request per lane.

**Gate FSM**
- IDLE:
  - If pend_out is set: go to OPEN, gate_dir = 1, clear pend_out, decrement occupancy.
  - Else if pend_in is set and occupancy < CAP: go to OPEN, gate_dir = 0, clear pend_in, increment occupancy.
  - Exit has priority when both flags are set.
- OPEN:
  - gate_open = 1; hold counter loads GATE_HOLD-1 on entry to the state.
  - Decrement each cycle; at 0 return to IDLE with gate_open = 0.
- gate_dir holds its value through IDLE until the next grant.
- Events arriving during OPEN only set flags; they are served after return to IDLE.
- full is registered from the updated occupancy on the same edge.

**Boundary conditions**
- Occupancy never exceeds CAP and never wraps below 0.
- A pend_in still set when occupancy reaches CAP is held, not dropped. It is served after an exit frees space.
- Simultaneous entry and exit car_evt in one cycle: both flags set; exit is served first.
- rst_n asserted mid-OPEN: gate_open drops immediately (asynchronous) and occupancy clears to 0.

## Timing

- Falling edge visible in cycle k → pend flag set at edge k+1 → FSM grants at edge k+2.
- gate_open is high for cycles k+2 .. k+2+GATE_HOLD-1.
- occupancy and full update at edge k+2.
- entry_reject and err_underflow are high for exactly one cycle, at edge k+1.
- Back-to-back service: the FSM spends at least one cycle in IDLE between openings, so gate_open deasserts for at least 1 cycle.

## Structure

- Package parking_pkg holds:
  - state typedef {IDLE, OPEN};
  - GATE_DIR_IN and GATE_DIR_OUT constants;
  - default CAR_MIN, CAR_MAX and GATE_HOLD values.
- Sub-module tyre_pulse_classifier contains db_q, the saturating width counter and the window compare. It is instantiated once per lane.
- Top level holds the pending flags, FSM, hold counter and occupancy counter.

## Test plan

- **Entry width 5 at occupancy 0:** gate_open high for 8 cycles starting 2 cycles after the fall; gate_dir = 0; occupancy = 1.
- **Width sweep:** entry pulses of width 1, 2, 10, 11 and 20 (saturating). Only widths 2 and 10 open the gate; final occupancy = 2.
- **Full park:**
  - preload 16 entries; full = 1;
  - entry width 4: entry_reject pulses once, occupancy stays 16;
  - exit width 4: occupancy = 15, full = 0.
- **Exit at occupancy 0:** err_underflow pulses once; gate_open stays 0; occupancy stays 0.
- **Simultaneous events at occupancy 3:** entry and exit falls in the same cycle. Outbound opening first (occupancy 2), ≥1 idle cycle, then inbound opening (occupancy 3).
- **Reset mid-operation:** rst_n = 1 during the 4th OPEN cycle. gate_open = 0, occupancy = 0 and pending flags clear asynchronously; no opening follows release.
